// File: rtl/bp_cacc_flit_arbiter.sv
// rtl/bp_cacc_flit_arbiter.sv - packet-atomic flit arbiter with per-input FIFOs and round-robin/fixed priority
module bp_cacc_flit_arbiter #(
  parameter int num_in_p     = 2,
  parameter int flit_width_p = 64,
  parameter int cord_width_p = 8,
  parameter int len_width_p  = 4,
  parameter int fifo_els_p   = 2,
  parameter int rr_mode_p    = 1
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_in_p*flit_width_p-1:0] data_i,
  input  logic [num_in_p-1:0]              v_i,
  output logic [num_in_p-1:0]              ready_o,
  output logic [flit_width_p-1:0]          data_o,
  output logic                             v_o,
  input  logic                             ready_i,
  output logic [$clog2(num_in_p)-1:0]      grant_id_o,
  output logic [15:0]                      pkt_count_o
);

  localparam int id_w = $clog2(num_in_p);
  localparam int aw   = $clog2(fifo_els_p);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e                  r_state, w_state_n;
  logic [id_w-1:0]         r_lock, w_lock_n;
  logic [len_width_p-1:0]  r_cnt, w_cnt_n;
  logic [id_w-1:0]         r_rr_ptr, w_rr_n;
  logic [15:0]             r_pkt_cnt;
  logic                    w_pkt_inc;

  logic [num_in_p-1:0]     w_empty;
  logic [num_in_p-1:0]     w_full;
  logic [flit_width_p-1:0] w_head [num_in_p];
  logic [id_w-1:0]         w_grant, w_rr_pick, w_fix_pick;
  logic                    w_hs;
  logic [len_width_p-1:0]  w_hdr_len;
  int                      w_idx;

  // Wrap-around successor of a channel index; used to rotate priority past the last winner.
  function automatic logic [id_w-1:0] f_next(input logic [id_w-1:0] g);
    return (32'(g) == 32'(num_in_p - 1)) ? '0 : g + 1'b1;
  endfunction

  for (genvar g = 0; g < num_in_p; g++) begin : g_fifo
    logic [flit_width_p-1:0] r_mem [fifo_els_p];
    logic [aw:0]             r_wptr, r_rptr;
    logic                    w_enq, w_deq;

    assign w_empty[g] = (r_wptr == r_rptr);
    assign w_full[g]  = (r_wptr[aw] != r_rptr[aw]) && (r_wptr[aw-1:0] == r_rptr[aw-1:0]);
    assign ready_o[g] = ~w_full[g];
    assign w_enq      = v_i[g] & ~w_full[g];
    assign w_deq      = w_hs & (w_grant == id_w'(g));
    assign w_head[g]  = r_mem[r_rptr[aw-1:0]];

    // Per-channel circular buffer; extra pointer bit distinguishes full from empty.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_wptr <= '0;
        r_rptr <= '0;
        for (int k = 0; k < fifo_els_p; k++) r_mem[k] <= '0;
      end else begin
        if (w_enq) begin
          r_mem[r_wptr[aw-1:0]] <= data_i[g*flit_width_p +: flit_width_p];
          r_wptr                <= r_wptr + 1'b1;
        end
        if (w_deq) r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  // Winner selection: lowest non-empty index, or first non-empty at/after rr_ptr; locked while mid-packet.
  always_comb begin
    w_fix_pick = '0;
    w_rr_pick  = '0;
    w_idx      = 0;
    for (int k = num_in_p - 1; k >= 0; k--) begin
      if (!w_empty[k]) w_fix_pick = id_w'(k);
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= num_in_p) w_idx = w_idx - num_in_p;
      if (!w_empty[w_idx]) w_rr_pick = id_w'(w_idx);
    end
    if (r_state == BUSY)     w_grant = r_lock;
    else if (rr_mode_p != 0) w_grant = w_rr_pick;
    else                     w_grant = w_fix_pick;
  end

  assign data_o      = w_head[w_grant];
  assign v_o         = ~w_empty[w_grant];
  assign w_hs        = v_o & ready_i;
  assign grant_id_o  = w_grant;
  assign pkt_count_o = r_pkt_cnt;
  assign w_hdr_len   = data_o[cord_width_p+len_width_p-1:cord_width_p];

  // Next-state logic: headers with a body lock the grant until the body count runs out.
  always_comb begin
    w_state_n = r_state;
    w_lock_n  = r_lock;
    w_cnt_n   = r_cnt;
    w_rr_n    = r_rr_ptr;
    w_pkt_inc = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          if (w_hdr_len == '0) begin
            w_pkt_inc = 1'b1;
            w_rr_n    = f_next(w_grant);
          end else begin
            w_state_n = BUSY;
            w_lock_n  = w_grant;
            w_cnt_n   = w_hdr_len;
          end
        end
      end
      BUSY: begin
        if (w_hs) begin
          w_cnt_n = r_cnt - 1'b1;
          if (r_cnt == len_width_p'(1)) begin
            w_state_n = IDLE;
            w_pkt_inc = 1'b1;
            w_rr_n    = f_next(r_lock);
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= IDLE;
    else            r_state <= w_state_n;
  end

  // Grant lock, body counter, priority pointer and completed-packet counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_lock    <= '0;
      r_cnt     <= '0;
      r_rr_ptr  <= '0;
      r_pkt_cnt <= '0;
    end else begin
      r_lock   <= w_lock_n;
      r_cnt    <= w_cnt_n;
      r_rr_ptr <= w_rr_n;
      if (w_pkt_inc) r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_bp_cacc_flit_arbiter.sv
// tb/tb_bp_cacc_flit_arbiter.sv - directed vector bench for bp_cacc_flit_arbiter
module tb_bp_cacc_flit_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] data_i;
  logic [3:0]  v_i;
  logic        ready_i;
  logic [3:0]  ready_o;
  logic [15:0] data_o;
  logic        v_o;
  logic [1:0]  grant;
  logic [15:0] pkt;

  logic [63:0] data_fp;
  logic [3:0]  v_fp;
  logic        rdy_fp;
  logic [3:0]  ready_o_fp;
  logic [15:0] data_o_fp;
  logic        v_o_fp;
  logic [1:0]  grant_fp;
  logic [15:0] pkt_fp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bp_cacc_flit_arbiter #(
    .num_in_p(4), .flit_width_p(16), .cord_width_p(8), .len_width_p(4),
    .fifo_els_p(2), .rr_mode_p(1)
  ) u_rr (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
    .data_o(data_o), .v_o(v_o), .ready_i(ready_i), .grant_id_o(grant), .pkt_count_o(pkt)
  );

  bp_cacc_flit_arbiter #(
    .num_in_p(4), .flit_width_p(16), .cord_width_p(8), .len_width_p(4),
    .fifo_els_p(2), .rr_mode_p(0)
  ) u_fp (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(data_fp), .v_i(v_fp), .ready_o(ready_o_fp),
    .data_o(data_o_fp), .v_o(v_o_fp), .ready_i(rdy_fp), .grant_id_o(grant_fp), .pkt_count_o(pkt_fp)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [63:0] d;
    logic        rdy;
    logic        ev;
    logic [1:0]  eg;
    logic [15:0] ed;
    logic [3:0]  er;
    logic [15:0] ep;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] v,
                              input logic [15:0] d3, input logic [15:0] d2,
                              input logic [15:0] d1, input logic [15:0] d0,
                              input logic rdy, input logic ev, input logic [1:0] eg,
                              input logic [15:0] ed, input logic [3:0] er, input logic [15:0] ep);
    vec_t t;
    t.rst = rst; t.v = v; t.d = {d3, d2, d1, d0}; t.rdy = rdy;
    t.ev = ev; t.eg = eg; t.ed = ed; t.er = er; t.ep = ep;
    return t;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input logic ev, input logic [1:0] eg,
                           input logic [15:0] ed, input logic [3:0] er, input logic [15:0] ep);
    cmp({nm, ".v_o"}, 64'(v_o), 64'(ev));
    cmp({nm, ".grant"}, 64'(grant), 64'(eg));
    if (ev) cmp({nm, ".data_o"}, 64'(data_o), 64'(ed));
    cmp({nm, ".ready_o"}, 64'(ready_o), 64'(er));
    cmp({nm, ".pkt"}, 64'(pkt), 64'(ep));
  endtask

  task automatic step(input logic [3:0] v, input logic [63:0] d, input logic rdy);
    v_i = v; data_i = d; ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    v_i = '0; data_i = '0; ready_i = 1'b1;
    v_fp = '0; data_fp = '0; rdy_fp = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    check_out("reset", 1'b0, 2'd0, 16'h0, 4'b1111, 16'd0);
    cmp("reset.fp_v_o", 64'(v_o_fp), 64'd0);
    cmp("reset.fp_ready", 64'(ready_o_fp), 64'hf);

    // single flit on ch1; ch0 3-flit packet against ch1 1-flit; 4-way round-robin stream
    tbl.push_back(mk(1, 4'b0010, 0, 0, 16'h1001, 0, 1, 1, 1, 16'h1001, 4'b1111, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0,            1, 0, 0, 16'h0,    4'b1111, 1));
    tbl.push_back(mk(0, 4'b0011, 0, 0, 16'h3001, 16'h2200, 1, 1, 0, 16'h2200, 4'b1111, 1));
    tbl.push_back(mk(0, 4'b0001, 0, 0, 0, 16'h4000,     1, 1, 0, 16'h4000, 4'b1111, 1));
    tbl.push_back(mk(0, 4'b0001, 0, 0, 0, 16'h5000,     1, 1, 0, 16'h5000, 4'b1111, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0,            1, 1, 1, 16'h3001, 4'b1111, 2));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0,            1, 0, 0, 16'h0,    4'b1111, 3));
    tbl.push_back(mk(1, 4'b1111, 16'hB003, 16'hA002, 16'h9001, 16'h8000, 1, 1, 0, 16'h8000, 4'b1111, 0));
    tbl.push_back(mk(0, 4'b1111, 16'hB003, 16'hA002, 16'h9001, 16'h8000, 1, 1, 1, 16'h9001, 4'b0001, 1));
    tbl.push_back(mk(0, 4'b1111, 16'hB003, 16'hA002, 16'h9001, 16'h8000, 1, 1, 2, 16'hA002, 4'b0010, 2));
    tbl.push_back(mk(0, 4'b1111, 16'hB003, 16'hA002, 16'h9001, 16'h8000, 1, 1, 3, 16'hB003, 4'b0100, 3));
    tbl.push_back(mk(0, 4'b1111, 16'hB003, 16'hA002, 16'h9001, 16'h8000, 1, 1, 0, 16'h8000, 4'b1000, 4));
    tbl.push_back(mk(0, 4'b1111, 16'hB003, 16'hA002, 16'h9001, 16'h8000, 1, 1, 1, 16'h9001, 4'b0001, 5));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].v, tbl[i].d, tbl[i].rdy);
      check_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eg, tbl[i].ed, tbl[i].er, tbl[i].ep);
    end

    // fixed priority: ch0 wins every time under full load
    do_reset();
    v_fp = 4'b1111; data_fp = {16'hB003, 16'hA002, 16'h9001, 16'h8000}; rdy_fp = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      cmp($sformatf("fp%0d.grant", k), 64'(grant_fp), 64'd0);
      cmp($sformatf("fp%0d.v_o", k), 64'(v_o_fp), 64'd1);
      cmp($sformatf("fp%0d.pkt", k), 64'(pkt_fp), 64'(k - 1));
      cmp($sformatf("fp%0d.ready", k), 64'(ready_o_fp), (k == 1) ? 64'hf : 64'h1);
    end
    v_fp = '0;

    // backpressure: ch0 fills its 2-deep buffer, head held stable, in-order drain
    do_reset();
    step(4'b0001, 64'hA010, 0); check_out("bp1", 1, 0, 16'hA010, 4'b1111, 0);
    step(4'b0001, 64'hA020, 0); check_out("bp2", 1, 0, 16'hA010, 4'b1110, 0);
    for (int k = 0; k < 3; k++) begin
      step(4'b0001, 64'hA030, 0);
      check_out($sformatf("bp_hold%0d", k), 1, 0, 16'hA010, 4'b1110, 0);
    end
    step(4'b0001, 64'hA030, 1); check_out("bp6", 1, 0, 16'hA020, 4'b1111, 1);
    step(4'b0001, 64'hA030, 1); check_out("bp7", 1, 0, 16'hA030, 4'b1111, 2);
    step(4'b0001, 64'hA040, 1); check_out("bp8", 1, 0, 16'hA040, 4'b1111, 3);
    step(4'b0000, 64'h0, 1);    check_out("bp9", 0, 0, 16'h0,    4'b1111, 4);

    // ch2 packet stalls mid-body while ch0 waits; grant stays locked
    do_reset();
    step(4'b0100, 64'hC302_0000_0000, 1);           check_out("lk1", 1, 2, 16'hC302, 4'b1111, 0);
    step(4'b0101, 64'hD002_0000_7000, 1);           check_out("lk2", 1, 2, 16'hD002, 4'b1111, 0);
    for (int k = 0; k < 3; k++) begin
      step(4'b0000, 64'h0, 1);
      check_out($sformatf("lk_stall%0d", k), 0, 2, 16'h0, 4'b1111, 0);
    end
    step(4'b0100, 64'hE002_0000_0000, 1);           check_out("lk6", 1, 2, 16'hE002, 4'b1111, 0);
    step(4'b0100, 64'hF002_0000_0000, 1);           check_out("lk7", 1, 2, 16'hF002, 4'b1111, 0);
    step(4'b0000, 64'h0, 1);                         check_out("lk8", 1, 0, 16'h7000, 4'b1111, 1);
    step(4'b0000, 64'h0, 1);                         check_out("lk9", 0, 0, 16'h0,    4'b1111, 2);

    // asynchronous reset in the middle of a locked packet with flits buffered
    do_reset();
    step(4'b0011, 64'h1201_6000, 1);  check_out("ar1", 1, 0, 16'h6000, 4'b1111, 0);
    step(4'b0010, 64'h2201_0000, 1);  check_out("ar2", 1, 1, 16'h1201, 4'b1101, 1);
    step(4'b0000, 64'h0, 1);          check_out("ar3", 1, 1, 16'h2201, 4'b1111, 1);
    ready_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("ar_async", 0, 0, 16'h0, 4'b1111, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(4'b0000, 64'h0, 1);
      check_out($sformatf("ar_post%0d", k), 0, 0, 16'h0, 4'b1111, 0);
    end
    step(4'b1000, 64'h3003_0000_0000_0000, 1); check_out("ar_new", 1, 3, 16'h3003, 4'b1111, 0);
    step(4'b0000, 64'h0, 1);                   check_out("ar_done", 0, 0, 16'h0, 4'b1111, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
